// File: rtl/acc_adder_pkg.sv
// Shared definitions for the packet accumulator: FSM state type and
// adder architecture indices used to select the ADDER implementation.
package acc_adder_pkg;

  localparam int ADDER_RCA   = 32'sd0;
  localparam int ADDER_CLA   = 32'sd1;
  localparam int ADDER_APA   = 32'sd2;
  localparam int ADDER_APAII = 32'sd3;
  localparam int ADDER_ETAI  = 32'sd4;
  localparam int ADDER_LOA   = 32'sd5;
  localparam int ADDER_MA    = 32'sd6;
  localparam int ADDER_TA    = 32'sd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } acc_state_e;

  // True for architectures whose low NB_APPROX_BITS are computed approximately.
  function automatic logic is_approx(input int adder_type);
    return (adder_type >= ADDER_APA) && (adder_type <= ADDER_TA);
  endfunction

endpackage

// File: rtl/acc_adder_if.sv
// Operand/result handshake bundle of the accumulator; the master drives
// operands and result acceptance, the slave is the accumulator itself.
interface acc_adder_if #(
  parameter int BITWIDTH  = 8,
  parameter int ACC_WIDTH = 16,
  parameter int CNT_WIDTH = 8
);

  logic                 in_valid;
  logic                 in_ready;
  logic [BITWIDTH-1:0]  in_data;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] out_data;
  logic [CNT_WIDTH-1:0] out_count;
  logic                 out_ovf;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count, out_ovf
  );

endinterface

// File: rtl/acc_adder_adder.sv
// Width-parametrised adder: exact ripple/lookahead, or one of several
// approximate schemes on the low NB_APPROX_BITS with an exact upper part.
module acc_adder_adder
  import acc_adder_pkg::*;
#(
  parameter int ADDERTYPE      = 0,
  parameter int SUBADDERTYPE   = 1,
  parameter int BITWIDTH       = 8,
  parameter int NB_APPROX_BITS = 2
) (
  input  logic [BITWIDTH-1:0] a_i,
  input  logic [BITWIDTH-1:0] b_i,
  output logic [BITWIDTH-1:0] sum_o
);

  localparam int K   = is_approx(ADDERTYPE) ? NB_APPROX_BITS : 0;
  localparam int KM1 = (K > 0) ? (K - 1) : 0;
  // Exact architectures pick their own carry scheme; approximate ones defer to SUBADDERTYPE.
  localparam int EXACT_KIND = (ADDERTYPE == ADDER_RCA) ? ADDER_RCA :
                              (ADDERTYPE == ADDER_CLA) ? ADDER_CLA : SUBADDERTYPE;
  localparam logic [BITWIDTH-1:0] LO_MASK = ~({BITWIDTH{1'b1}} << K);

  logic [BITWIDTH-1:0] lo_s;
  logic [BITWIDTH-1:0] hi_s;
  logic                cin_s;
  logic                hit_s;
  logic                carry_s;
  logic                cla_c_s;
  logic                cla_p_s;

  // Approximate low part and the carry it hands to the exact upper part.
  always_comb begin
    lo_s  = '0;
    cin_s = 1'b0;
    hit_s = 1'b0;
    case (ADDERTYPE)
      ADDER_APA: begin
        lo_s = a_i ^ b_i;
      end
      ADDER_APAII: begin
        lo_s  = a_i ^ b_i;
        cin_s = (K > 0) ? (a_i[KM1] & b_i[KM1]) : 1'b0;
      end
      ADDER_ETAI: begin
        for (int i = BITWIDTH - 1; i >= 0; i--) begin
          if (i >= K) begin
            lo_s[i] = 1'b0;
          end else if (hit_s) begin
            lo_s[i] = 1'b1;
          end else if (a_i[i] & b_i[i]) begin
            lo_s[i] = 1'b1;
            hit_s   = 1'b1;
          end else begin
            lo_s[i] = a_i[i] ^ b_i[i];
          end
        end
      end
      ADDER_LOA: begin
        lo_s  = a_i | b_i;
        cin_s = (K > 0) ? (a_i[KM1] & b_i[KM1]) : 1'b0;
      end
      ADDER_MA: begin
        lo_s  = b_i;
        cin_s = (K > 0) ? a_i[KM1] : 1'b0;
      end
      ADDER_TA: begin
        lo_s = '0;
      end
      default: begin
        lo_s = '0;
      end
    endcase
  end

  // Exact part from bit K upward, carries rippled or looked ahead.
  always_comb begin
    hi_s    = '0;
    carry_s = cin_s;
    cla_c_s = 1'b0;
    cla_p_s = 1'b1;
    for (int i = 0; i < BITWIDTH; i++) begin
      if (i < K) begin
        hi_s[i] = 1'b0;
      end else if (EXACT_KIND == ADDER_CLA) begin
        cla_c_s = 1'b0;
        cla_p_s = 1'b1;
        for (int j = i - 1; j >= K; j--) begin
          cla_c_s = cla_c_s | (cla_p_s & a_i[j] & b_i[j]);
          cla_p_s = cla_p_s & (a_i[j] ^ b_i[j]);
        end
        cla_c_s = cla_c_s | (cla_p_s & cin_s);
        hi_s[i] = a_i[i] ^ b_i[i] ^ cla_c_s;
      end else begin
        hi_s[i] = a_i[i] ^ b_i[i] ^ carry_s;
        carry_s = (a_i[i] & b_i[i]) | (carry_s & (a_i[i] ^ b_i[i]));
      end
    end
  end

  assign sum_o = (lo_s & LO_MASK) | (hi_s & ~LO_MASK);

endmodule

// File: rtl/acc_adder.sv
// Packet accumulator: sums operand beats until in_last, then holds the
// result (sum, beat count, sticky overflow) until the consumer takes it.
module acc_adder
  import acc_adder_pkg::*;
#(
  parameter int ADDERTYPE      = 0,
  parameter int SUBADDERTYPE   = 1,
  parameter int BITWIDTH       = 8,
  parameter int ACC_WIDTH      = 16,
  parameter int NB_APPROX_BITS = 2,
  parameter int SIGNED         = 1,
  parameter int SATURATE       = 0,
  parameter int CNT_WIDTH      = 8
) (
  input logic        clk,
  input logic        rst,
  input logic        clr,
  acc_adder_if.slave acc_if
);

  localparam int MSB = ACC_WIDTH - 1;
  localparam logic [ACC_WIDTH-1:0] U_MAX   = {ACC_WIDTH{1'b1}};
  localparam logic [ACC_WIDTH-1:0] S_MAX   = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] S_MIN   = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  acc_state_e           state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic                 sat_q, sat_d;

  logic [ACC_WIDTH-1:0] base_s;
  logic [ACC_WIDTH-1:0] opnd_s;
  logic [ACC_WIDTH-1:0] sum_s;
  logic [ACC_WIDTH-1:0] clamp_s;
  logic [CNT_WIDTH-1:0] cnt_base_s;
  logic                 ovf_base_s;
  logic                 sat_base_s;
  logic                 ovf_s;
  logic                 ready_s;
  logic                 beat_s;

  assign ready_s = !rst && !clr && ((state_q != ST_DONE) || acc_if.out_ready);
  assign beat_s  = acc_if.in_valid && ready_s;

  // Widen the operand to accumulator width.
  always_comb begin
    if (SIGNED != 0) begin
      opnd_s = ACC_WIDTH'($signed(acc_if.in_data));
    end else begin
      opnd_s = ACC_WIDTH'(acc_if.in_data);
    end
  end

  // Only ACC continues a packet; IDLE and DONE start a fresh one from zero.
  always_comb begin
    if (state_q == ST_ACC) begin
      base_s     = acc_q;
      cnt_base_s = cnt_q;
      ovf_base_s = ovf_q;
      sat_base_s = sat_q;
    end else begin
      base_s     = '0;
      cnt_base_s = '0;
      ovf_base_s = 1'b0;
      sat_base_s = 1'b0;
    end
  end

  acc_adder_adder #(
    .ADDERTYPE      (ADDERTYPE),
    .SUBADDERTYPE   (SUBADDERTYPE),
    .BITWIDTH       (ACC_WIDTH),
    .NB_APPROX_BITS (NB_APPROX_BITS)
  ) u_adder (
    .a_i   (base_s),
    .b_i   (opnd_s),
    .sum_o (sum_s)
  );

  // Overflow is judged on the adder output, so approximate sums are checked as produced.
  always_comb begin
    if (SIGNED != 0) begin
      ovf_s   = (base_s[MSB] == opnd_s[MSB]) && (sum_s[MSB] != base_s[MSB]);
      clamp_s = opnd_s[MSB] ? S_MIN : S_MAX;
    end else begin
      ovf_s   = (sum_s < base_s);
      clamp_s = U_MAX;
    end
  end

  // Packet FSM and accumulator update.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    sat_d   = sat_q;
    if (clr) begin
      state_d = ST_IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
      sat_d   = 1'b0;
    end else if (beat_s) begin
      state_d = acc_if.in_last ? ST_DONE : ST_ACC;
      cnt_d   = (&cnt_base_s) ? cnt_base_s : (cnt_base_s + CNT_ONE);
      ovf_d   = ovf_base_s | ovf_s;
      if (sat_base_s) begin
        acc_d = base_s;
        sat_d = 1'b1;
      end else if ((SATURATE != 0) && ovf_s) begin
        acc_d = clamp_s;
        sat_d = 1'b1;
      end else begin
        acc_d = sum_s;
        sat_d = 1'b0;
      end
    end else if ((state_q == ST_DONE) && acc_if.out_ready) begin
      state_d = ST_IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
      sat_d   = 1'b0;
    end else begin
      state_d = state_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      sat_q   <= sat_d;
    end
  end

  assign acc_if.in_ready  = ready_s;
  assign acc_if.out_valid = (state_q == ST_DONE);
  assign acc_if.out_data  = acc_q;
  assign acc_if.out_count = cnt_q;
  assign acc_if.out_ovf   = ovf_q;

endmodule

// File: tb/tb_acc_adder.sv
// Bench for acc_adder: five configurations share one handshake stream and
// are checked by directed scenarios plus randomized packets against a model.
module tb_acc_adder;

  logic       clk = 1'b0;
  logic       rst, clr;
  logic       tb_valid, tb_last, tb_oready;
  logic [7:0] tb_data, tb_data3;
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  acc_adder_if #(.BITWIDTH(8), .ACC_WIDTH(16), .CNT_WIDTH(8)) bus0 ();
  acc_adder_if #(.BITWIDTH(8), .ACC_WIDTH(8),  .CNT_WIDTH(8)) bus1 ();
  acc_adder_if #(.BITWIDTH(8), .ACC_WIDTH(8),  .CNT_WIDTH(8)) bus2 ();
  acc_adder_if #(.BITWIDTH(8), .ACC_WIDTH(8),  .CNT_WIDTH(8)) bus3 ();
  acc_adder_if #(.BITWIDTH(8), .ACC_WIDTH(16), .CNT_WIDTH(8)) bus4 ();

  assign bus0.in_valid = tb_valid; assign bus0.in_data = tb_data;  assign bus0.in_last = tb_last; assign bus0.out_ready = tb_oready;
  assign bus1.in_valid = tb_valid; assign bus1.in_data = tb_data;  assign bus1.in_last = tb_last; assign bus1.out_ready = tb_oready;
  assign bus2.in_valid = tb_valid; assign bus2.in_data = tb_data;  assign bus2.in_last = tb_last; assign bus2.out_ready = tb_oready;
  assign bus3.in_valid = tb_valid; assign bus3.in_data = tb_data3; assign bus3.in_last = tb_last; assign bus3.out_ready = tb_oready;
  assign bus4.in_valid = tb_valid; assign bus4.in_data = tb_data;  assign bus4.in_last = tb_last; assign bus4.out_ready = tb_oready;

  acc_adder #(.ADDERTYPE(0), .ACC_WIDTH(16), .SIGNED(1), .SATURATE(0))
    u0 (.clk(clk), .rst(rst), .clr(clr), .acc_if(bus0));
  acc_adder #(.ADDERTYPE(0), .ACC_WIDTH(8), .SIGNED(1), .SATURATE(1))
    u1 (.clk(clk), .rst(rst), .clr(clr), .acc_if(bus1));
  acc_adder #(.ADDERTYPE(0), .ACC_WIDTH(8), .SIGNED(1), .SATURATE(0))
    u2 (.clk(clk), .rst(rst), .clr(clr), .acc_if(bus2));
  acc_adder #(.ADDERTYPE(0), .ACC_WIDTH(8), .SIGNED(0), .SATURATE(0))
    u3 (.clk(clk), .rst(rst), .clr(clr), .acc_if(bus3));
  acc_adder #(.ADDERTYPE(5), .NB_APPROX_BITS(2), .ACC_WIDTH(16), .SIGNED(1), .SATURATE(0))
    u4 (.clk(clk), .rst(rst), .clr(clr), .acc_if(bus4));

  typedef struct packed {
    logic [15:0] de;
    logic [15:0] dl;
    logic [7:0]  c;
    logic        oe;
    logic        ol;
  } res_t;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    tb_valid = 1'b1; tb_data = d; tb_data3 = d; tb_last = l;
    tick();
  endtask

  task automatic idle();
    tb_valid = 1'b0; tb_last = 1'b0;
  endtask

  // Lower-part-OR adder on 16 bits with 2 approximate LSBs.
  function automatic logic [15:0] loa16(input logic [15:0] a, input logic [15:0] b);
    logic [13:0] hi;
    hi = a[15:2] + b[15:2] + {13'd0, a[1] & b[1]};
    return {hi, a[1:0] | b[1:0]};
  endfunction

  task automatic test_reset();
    rst = 1'b1; idle(); tb_oready = 1'b1;
    tick(); tick();
    total++;
    if (bus0.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", bus0.in_ready); end
    total++;
    if ({bus0.out_valid, bus0.out_data, bus0.out_count, bus0.out_ovf} !== 26'd0) begin
      bad++; $display("FAIL reset_outputs got v=%b d=%h c=%0d o=%b want all 0",
                      bus0.out_valid, bus0.out_data, bus0.out_count, bus0.out_ovf);
    end
    rst = 1'b0; #1;
    total++;
    if (bus0.in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready got=%b want=1", bus0.in_ready); end
    tick();
  endtask

  task automatic test_basic();
    send(8'd3, 1'b0); send(8'hFB, 1'b0); send(8'd10, 1'b1); idle();
    total++;
    if (bus0.out_valid !== 1'b1 || bus0.out_data !== 16'd8 || bus0.out_count !== 8'd3 || bus0.out_ovf !== 1'b0) begin
      bad++; $display("FAIL basic_result got v=%b d=%0d c=%0d o=%b want v=1 d=8 c=3 o=0",
                      bus0.out_valid, bus0.out_data, bus0.out_count, bus0.out_ovf);
    end
    tick();
    total++;
    if (bus0.out_valid !== 1'b0) begin bad++; $display("FAIL basic_to_idle got v=%b want 0", bus0.out_valid); end
  endtask

  task automatic test_back_to_back();
    send(8'd1, 1'b0); send(8'd2, 1'b1);
    tb_oready = 1'b0; tb_valid = 1'b1; tb_data = 8'd7; tb_data3 = 8'd7; tb_last = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      total++;
      if (bus0.in_ready !== 1'b0 || bus0.out_valid !== 1'b1 || bus0.out_data !== 16'd3) begin
        bad++; $display("FAIL hold_cycle%0d got rdy=%b v=%b d=%0d want rdy=0 v=1 d=3",
                        c, bus0.in_ready, bus0.out_valid, bus0.out_data);
      end
      tick();
    end
    tb_oready = 1'b1; #1;
    total++;
    if (bus0.in_ready !== 1'b1) begin bad++; $display("FAIL release_ready got=%b want=1", bus0.in_ready); end
    tick(); idle();
    total++;
    if (bus0.out_valid !== 1'b1 || bus0.out_data !== 16'd7 || bus0.out_count !== 8'd1) begin
      bad++; $display("FAIL zero_bubble got v=%b d=%0d c=%0d want v=1 d=7 c=1",
                      bus0.out_valid, bus0.out_data, bus0.out_count);
    end
    tick();
  endtask

  task automatic test_overflow();
    tb_oready = 1'b1; tb_valid = 1'b1;
    tb_data = 8'd100; tb_data3 = 8'd200; tb_last = 1'b0; tick();
    tb_data = 8'd100; tb_data3 = 8'd100; tb_last = 1'b1; tick(); idle();
    total++;
    if (bus1.out_data !== 8'd127 || bus1.out_ovf !== 1'b1) begin bad++; $display("FAIL sat_clamp got d=%0d o=%b want d=127 o=1", bus1.out_data, bus1.out_ovf); end
    total++;
    if (bus2.out_data !== 8'hC8 || bus2.out_ovf !== 1'b1) begin bad++; $display("FAIL wrap got d=%h o=%b want d=c8 o=1", bus2.out_data, bus2.out_ovf); end
    total++;
    if (bus3.out_data !== 8'd44 || bus3.out_ovf !== 1'b1) begin bad++; $display("FAIL unsigned_ovf got d=%0d o=%b want d=44 o=1", bus3.out_data, bus3.out_ovf); end
    total++;
    if (bus0.out_data !== 16'd200 || bus0.out_ovf !== 1'b0) begin bad++; $display("FAIL wide_no_ovf got d=%0d o=%b want d=200 o=0", bus0.out_data, bus0.out_ovf); end
    tick();
    tb_valid = 1'b1;
    tb_data = 8'd100;  tb_data3 = 8'd10; tb_last = 1'b0; tick();
    tb_data = 8'd100;  tb_data3 = 8'd20; tick();
    tb_data = 8'hCE;   tb_data3 = 8'd30; tb_last = 1'b1; tick(); idle();
    total++;
    if (bus1.out_data !== 8'd127 || bus1.out_ovf !== 1'b1 || bus1.out_count !== 8'd3) begin
      bad++; $display("FAIL sat_sticky got d=%0d o=%b c=%0d want d=127 o=1 c=3", bus1.out_data, bus1.out_ovf, bus1.out_count);
    end
    total++;
    if (bus2.out_data !== 8'h96 || bus2.out_ovf !== 1'b1) begin bad++; $display("FAIL wrap_sticky got d=%h o=%b want d=96 o=1", bus2.out_data, bus2.out_ovf); end
    total++;
    if (bus3.out_data !== 8'd60 || bus3.out_ovf !== 1'b0) begin bad++; $display("FAIL ovf_cleared got d=%0d o=%b want d=60 o=0", bus3.out_data, bus3.out_ovf); end
    tick();
  endtask

  task automatic test_clear();
    send(8'd5, 1'b0); send(8'd5, 1'b0); idle();
    clr = 1'b1; #1;
    total++;
    if (bus0.in_ready !== 1'b0) begin bad++; $display("FAIL clr_ready got=%b want=0", bus0.in_ready); end
    tick(); clr = 1'b0;
    total++;
    if (bus0.out_valid !== 1'b0 || bus0.out_count !== 8'd0 || bus0.out_data !== 16'd0) begin
      bad++; $display("FAIL clr_state got v=%b c=%0d d=%0d want 0 0 0", bus0.out_valid, bus0.out_count, bus0.out_data);
    end
    send(8'd1, 1'b1); idle();
    total++;
    if (bus0.out_valid !== 1'b1 || bus0.out_data !== 16'd1 || bus0.out_count !== 8'd1) begin
      bad++; $display("FAIL clr_restart got v=%b d=%0d c=%0d want 1 1 1", bus0.out_valid, bus0.out_data, bus0.out_count);
    end
    tick();
    send(8'd5, 1'b0); send(8'd5, 1'b0); idle();
    rst = 1'b1; tick(); rst = 1'b0;
    total++;
    if (bus0.out_valid !== 1'b0 || bus0.out_count !== 8'd0) begin bad++; $display("FAIL rst_mid got v=%b c=%0d want 0 0", bus0.out_valid, bus0.out_count); end
    send(8'd1, 1'b1); idle();
    total++;
    if (bus0.out_valid !== 1'b1 || bus0.out_data !== 16'd1 || bus0.out_count !== 8'd1) begin
      bad++; $display("FAIL rst_restart got v=%b d=%0d c=%0d want 1 1 1", bus0.out_valid, bus0.out_data, bus0.out_count);
    end
    tick();
    tb_oready = 1'b0; send(8'd9, 1'b1); idle();
    rst = 1'b1; tick(); rst = 1'b0; tb_oready = 1'b1;
    total++;
    if (bus0.out_valid !== 1'b0 || bus0.out_data !== 16'd0) begin bad++; $display("FAIL rst_pending got v=%b d=%0d want 0 0", bus0.out_valid, bus0.out_data); end
    tick();
  endtask

  task automatic test_count_sat();
    tb_oready = 1'b1;
    for (int i = 0; i < 300; i++) send(8'd1, (i == 299));
    idle();
    total++;
    if (bus0.out_valid !== 1'b1 || bus0.out_data !== 16'd300 || bus0.out_count !== 8'd255) begin
      bad++; $display("FAIL count_sat got v=%b d=%0d c=%0d want v=1 d=300 c=255", bus0.out_valid, bus0.out_data, bus0.out_count);
    end
    tick();
  endtask

  task automatic test_random();
    res_t        q[$];
    res_t        cur;
    bit          have_cur = 1'b0;
    bit          in_pkt = 1'b0;
    logic [15:0] acc_e = '0, acc_l = '0, op, r;
    int          cnt_m = 0, s;
    logic        ovf_e = 1'b0, ovf_l = 1'b0, exp_valid, exp_ready;
    cur = '0;
    for (int cyc = 0; cyc < 1600; cyc++) begin
      exp_valid = have_cur || (q.size() != 0);
      if (!have_cur && q.size() != 0) begin cur = q.pop_front(); have_cur = 1'b1; end
      total++;
      if (bus0.out_valid !== exp_valid || bus4.out_valid !== exp_valid) begin
        bad++; $display("FAIL rnd_valid cyc=%0d got rca=%b loa=%b want %b", cyc, bus0.out_valid, bus4.out_valid, exp_valid);
      end
      if (have_cur) begin
        total++;
        if (bus0.out_data !== cur.de || bus0.out_count !== cur.c || bus0.out_ovf !== cur.oe ||
            bus4.out_data !== cur.dl || bus4.out_ovf !== cur.ol) begin
          bad++; $display("FAIL rnd_result cyc=%0d got rca=%h/%0d/%b loa=%h/%b want rca=%h/%0d/%b loa=%h/%b",
                          cyc, bus0.out_data, bus0.out_count, bus0.out_ovf, bus4.out_data, bus4.out_ovf,
                          cur.de, cur.c, cur.oe, cur.dl, cur.ol);
        end
      end
      tb_oready = (cyc >= 1500) ? 1'b1 : ($urandom_range(0, 3) != 0);
      tb_valid  = (cyc < 1500) && ($urandom_range(0, 3) != 0);
      tb_data   = 8'($urandom);
      tb_data3  = tb_data;
      tb_last   = ($urandom_range(0, 4) == 0);
      #1;
      exp_ready = !have_cur || tb_oready;
      total++;
      if (bus0.in_ready !== exp_ready) begin bad++; $display("FAIL rnd_ready cyc=%0d got=%b want=%b", cyc, bus0.in_ready, exp_ready); end
      if (tb_valid && exp_ready) begin
        if (!in_pkt) begin acc_e = '0; acc_l = '0; cnt_m = 0; ovf_e = 1'b0; ovf_l = 1'b0; end
        op = {{8{tb_data[7]}}, tb_data};
        s = int'($signed(acc_e)) + int'($signed(op));
        if (s > 32767 || s < -32768) ovf_e = 1'b1;
        acc_e = 16'(s);
        r = loa16(acc_l, op);
        if ((acc_l[15] == op[15]) && (r[15] != acc_l[15])) ovf_l = 1'b1;
        acc_l = r;
        cnt_m = (cnt_m < 255) ? cnt_m + 1 : 255;
        if (tb_last) begin
          q.push_back('{de: acc_e, dl: acc_l, c: 8'(cnt_m), oe: ovf_e, ol: ovf_l});
          in_pkt = 1'b0;
        end else begin
          in_pkt = 1'b1;
        end
      end
      if (have_cur && tb_oready) have_cur = 1'b0;
      tick();
    end
    idle();
  endtask

  initial begin
    tb_valid = 1'b0; tb_last = 1'b0; tb_data = 8'd0; tb_data3 = 8'd0;
    tb_oready = 1'b1; clr = 1'b0; rst = 1'b1;
    test_reset();
    test_basic();
    test_back_to_back();
    test_overflow();
    test_clear();
    test_count_sat();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
